// File: rtl/inter_packet_delay_mc_if.sv
// AXI-Stream bundle used on both sides of the inter-packet delay stage.
// The master drives the payload and tvalid, the slave drives tready.
interface inter_packet_delay_mc_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/inter_packet_delay_mc.sv
// Inter-packet delay stage: buffers AXI-Stream beats in a small fallthrough FIFO
// and withholds each packet header until the programmed gap has elapsed.
module inter_packet_delay_mc #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_DELAY_WIDTH        = 32,
    parameter int unsigned C_TUSER_DELAY_OFFSET = 32,
    parameter int unsigned C_FIFO_DEPTH_BITS    = 2
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    inter_packet_delay_mc_if.slave        s_axis,
    inter_packet_delay_mc_if.master       m_axis,
    input  logic                          sw_rst,
    input  logic [1:0]                    mode,
    input  logic                          gap_mode,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] delay_reg_val,
    output logic [31:0]                   pkt_count
);
    localparam int unsigned DW    = (C_M_AXIS_DATA_WIDTH < C_S_AXIS_DATA_WIDTH) ?
                                    C_M_AXIS_DATA_WIDTH : C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW    = (C_M_AXIS_TUSER_WIDTH < C_S_AXIS_TUSER_WIDTH) ?
                                    C_M_AXIS_TUSER_WIDTH : C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned PW    = DW + SW + UW + 1;
    localparam int unsigned AW    = C_FIFO_DEPTH_BITS;
    localparam int unsigned CW    = C_FIFO_DEPTH_BITS + 1;
    localparam int unsigned DEPTH = 1 << C_FIFO_DEPTH_BITS;
    localparam int unsigned GW    = C_DELAY_WIDTH;

    typedef enum logic {ST_HEADER = 1'b0, ST_BODY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d, dhold_q, dhold_d;
    logic [31:0]   pkt_q, pkt_d;
    logic [1:0]    mode_q, mode_d;
    logic          gmode_q, gmode_d;
    logic          en_q;

    logic [PW-1:0] head, wr_word;
    logic [DW-1:0] h_data;
    logic [SW-1:0] h_strb;
    logic [UW-1:0] h_user;
    logic          h_last;
    logic          bypass, empty, nearly_full, out_en;
    logic          m_valid_c, m_last_c, s_ready_c, m_hs, s_hs, wr_en, rd_en, latch_ok;
    logic [GW-1:0] d_reg, d_usr, d_sum, d_cur;
    logic [GW:0]   d_wide;

    if (C_S_AXI_DATA_WIDTH > C_DELAY_WIDTH) begin : g_unused_reg
        logic unused_reg_bits;
        assign unused_reg_bits = ^delay_reg_val[C_S_AXI_DATA_WIDTH-1:C_DELAY_WIDTH];
    end

    assign wr_word = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    assign head    = mem_q[rd_ptr_q];
    assign h_data  = head[DW-1:0];
    assign h_strb  = head[DW +: SW];
    assign h_user  = head[DW+SW +: UW];
    assign h_last  = head[PW-1];

    assign bypass      = (mode_q == 2'd0);
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= CW'(DEPTH - 1));
    // Output enable holds the ports quiet while either reset is active.
    assign out_en      = en_q && !sw_rst;
    assign pkt_count   = pkt_q;

    // Per-packet delay taken from the header beat at the FIFO head.
    always_comb begin
        d_reg  = delay_reg_val[GW-1:0];
        d_usr  = h_user[C_TUSER_DELAY_OFFSET +: GW];
        d_wide = {1'b0, d_reg} + {1'b0, d_usr};
        d_sum  = d_wide[GW] ? {GW{1'b1}} : d_wide[GW-1:0];
        case (mode_q)
            2'd1:    d_cur = d_reg;
            2'd2:    d_cur = d_usr;
            2'd3:    d_cur = d_sum;
            default: d_cur = '0;
        endcase
    end

    // Port muxing, FIFO bookkeeping, header/body FSM and gap countdown.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = (gap_q != '0) ? gap_q - GW'(1) : '0;
        dhold_d  = dhold_q;
        pkt_d    = pkt_q;
        mode_d   = mode_q;
        gmode_d  = gmode_q;

        if (bypass) begin
            m_axis.tdata  = s_axis.tdata;
            m_axis.tstrb  = s_axis.tstrb;
            m_axis.tuser  = s_axis.tuser;
            m_last_c      = out_en && s_axis.tlast;
            m_valid_c     = out_en && s_axis.tvalid;
            s_ready_c     = out_en && m_axis.tready;
        end else begin
            m_axis.tdata  = h_data;
            m_axis.tstrb  = h_strb;
            m_axis.tuser  = h_user;
            m_last_c      = h_last && !empty;
            m_valid_c     = out_en && !empty && ((state_q == ST_BODY) || (gap_q == '0));
            s_ready_c     = out_en && !nearly_full;
        end

        m_hs  = m_valid_c && m_axis.tready;
        s_hs  = s_axis.tvalid && s_ready_c;
        wr_en = !bypass && s_hs;
        rd_en = !bypass && m_hs;

        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(wr_en) - CW'(rd_en);

        if (m_hs) begin
            if (state_q == ST_HEADER) begin
                if (!bypass) begin
                    dhold_d = d_cur;
                    if (!gmode_q)
                        gap_d = (d_cur != '0) ? d_cur - GW'(1) : '0;
                    else if (m_last_c)
                        gap_d = d_cur;
                end
                if (!m_last_c) state_d = ST_BODY;
            end else if (m_last_c) begin
                state_d = ST_HEADER;
                if (!bypass && gmode_q) gap_d = dhold_q;
            end
            if (m_last_c) pkt_d = pkt_q + 32'd1;
        end

        // Mode is only sampled between packets with nothing buffered or arriving.
        latch_ok = (state_q == ST_HEADER) && empty && !m_hs && !wr_en;
        if (latch_ok) begin
            mode_d  = mode;
            gmode_d = gap_mode;
        end

        if (sw_rst) begin
            state_d  = ST_HEADER;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            gap_d    = '0;
            dhold_d  = '0;
            pkt_d    = '0;
            mode_d   = 2'd0;
            gmode_d  = 1'b0;
        end

        m_axis.tvalid = m_valid_c;
        m_axis.tlast  = m_last_c;
        s_axis.tready = s_ready_c;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= ST_HEADER;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            dhold_q  <= '0;
            pkt_q    <= '0;
            mode_q   <= 2'd0;
            gmode_q  <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            dhold_q  <= dhold_d;
            pkt_q    <= pkt_d;
            mode_q   <= mode_d;
            gmode_q  <= gmode_d;
            en_q     <= 1'b1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge axi_aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_word;
    end
endmodule

// File: tb/tb_inter_packet_delay_mc.sv
// Directed/randomised bench for inter_packet_delay_mc with a beat scoreboard
// and header/tlast timestamp log checked against the gap rules.
module tb_inter_packet_delay_mc;
    typedef struct packed {
        logic         last;
        logic [127:0] user;
        logic [31:0]  strb;
        logic [255:0] data;
    } beat_t;

    logic        clk;
    logic        axi_aresetn;
    logic        sw_rst;
    logic [1:0]  mode;
    logic        gap_mode;
    logic [31:0] delay_reg_val;
    logic [31:0] pkt_count;

    inter_packet_delay_mc_if #(.DATA_W(256), .USER_W(128)) s_if ();
    inter_packet_delay_mc_if #(.DATA_W(256), .USER_W(128)) m_if ();

    inter_packet_delay_mc dut (
        .axi_aclk      (clk),
        .axi_aresetn   (axi_aresetn),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .sw_rst        (sw_rst),
        .mode          (mode),
        .gap_mode      (gap_mode),
        .delay_reg_val (delay_reg_val),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    wr_t = 0;
    int    npkt = 0;
    int    mbeats = 0;
    logic  in_pkt = 1'b0;
    logic  src_en = 1'b0;
    logic  rnd_rdy = 1'b0;
    logic  rdy_val = 1'b1;
    beat_t src_q[$];
    beat_t exp_q[$];
    int    hdr_q[$];
    int    last_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_pkt(input int len, input logic [31:0] dfield);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.strb = $urandom;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) b.user[63:32] = dfield;
            b.last = (i == len - 1);
            src_q.push_back(b);
        end
    endtask

    task automatic drive();
        if (src_en && src_q.size() != 0) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = src_q[0].data;
            s_if.tstrb  = src_q[0].strb;
            s_if.tuser  = src_q[0].user;
            s_if.tlast  = src_q[0].last;
        end else begin
            s_if.tvalid = 1'b0;
        end
        m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
    endtask

    // One clock: observe handshakes at the falling edge, drive after the rising edge.
    task automatic tick();
        beat_t o;
        beat_t e;
        @(negedge clk);
        cyc++;
        if (s_if.tvalid && s_if.tready) begin
            if (src_q.size() != 0) exp_q.push_back(src_q.pop_front());
            wr_t = cyc;
        end
        if (m_if.tvalid && m_if.tready) begin
            o = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            n_chk++;
            assert (o === e) else begin
                n_err++;
                $error("FAIL beat obs=%h exp=%h", o, e);
            end
            if (!in_pkt) hdr_q.push_back(cyc);
            mbeats++;
            if (m_if.tlast) begin
                last_q.push_back(cyc);
                npkt++;
                in_pkt = 1'b0;
            end else begin
                in_pkt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clr_tb();
        src_q.delete();
        exp_q.delete();
        hdr_q.delete();
        last_q.delete();
        npkt   = 0;
        mbeats = 0;
        in_pkt = 1'b0;
    endtask

    task automatic do_swrst();
        sw_rst = 1'b1;
        src_en = 1'b0;
        tick();
        sw_rst = 1'b0;
        clr_tb();
    endtask

    task automatic setup(input logic [1:0] md, input logic gm, input logic [31:0] rv);
        do_swrst();
        mode          = md;
        gap_mode      = gm;
        delay_reg_val = rv;
        repeat (3) tick();
        src_en = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int b = 0;
        while (npkt < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, 32'(npkt), 32'(n));
    endtask

    initial begin
        int dl [3];
        int b;
        axi_aresetn   = 1'b0;
        sw_rst        = 1'b0;
        mode          = 2'd0;
        gap_mode      = 1'b0;
        delay_reg_val = '0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        s_if.tstrb    = '0;
        s_if.tuser    = '0;
        s_if.tlast    = 1'b0;
        m_if.tready   = 1'b0;
        #12;
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_s_tready", 32'(s_if.tready), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        @(posedge clk);
        #1;
        axi_aresetn = 1'b1;
        repeat (2) tick();

        // Register delay, start-to-start, continuous traffic: exact 10-cycle header spacing.
        setup(2'd1, 1'b0, 32'd10);
        for (int p = 0; p < 6; p++) gen_pkt(4, $urandom);
        run_until(6, 300, "s2s_done");
        tick();
        chk("s2s_pkt_count", pkt_count, 32'd6);
        for (int i = 0; i < 5; i++)
            if (hdr_q.size() > i + 1) chk("s2s_spacing", 32'(hdr_q[i+1] - hdr_q[i]), 32'd10);

        // Tuser delay, end-to-start: D idle cycles after each tlast.
        setup(2'd2, 1'b1, 32'd99);
        dl[0] = 0; dl[1] = 5; dl[2] = 3;
        for (int p = 0; p < 3; p++) gen_pkt(2, 32'(dl[p]));
        gen_pkt(2, 32'd0);
        run_until(4, 200, "e2s_done");
        for (int k = 0; k < 3; k++)
            if (hdr_q.size() > k + 1 && last_q.size() > k)
                chk("e2s_gap", 32'(hdr_q[k+1] - last_q[k]), 32'(dl[k] + 1));

        // Random backpressure with register delay 2.
        setup(2'd1, 1'b0, 32'd2);
        rnd_rdy = 1'b1;
        for (int p = 0; p < 10; p++) gen_pkt($urandom_range(1, 4), $urandom);
        run_until(10, 1500, "rnd_done");
        rnd_rdy = 1'b0;
        tick();
        chk("rnd_pkt_count", pkt_count, 32'd10);
        for (int i = 0; i + 1 < hdr_q.size(); i++)
            chk("rnd_gap_min", 32'((hdr_q[i+1] - hdr_q[i]) >= 2), 32'd1);

        // Mode 1 -> 0 mid-packet: packet drains from FIFO, then bypass.
        setup(2'd1, 1'b0, 32'd4);
        gen_pkt(6, 32'd0);
        b = 0;
        while (mbeats < 1 && b < 50) begin tick(); b++; end
        chk("mc_started", 32'(mbeats), 32'd1);
        mode    = 2'd0;
        rdy_val = 1'b0;
        repeat (4) tick();
        rdy_val = 1'b1;
        run_until(1, 100, "mc_done");
        repeat (3) tick();
        gen_pkt(1, 32'd0);
        drive();
        #1;
        chk("byp_valid", 32'(m_if.tvalid), 32'd1);
        chk("byp_data", m_if.tdata[31:0], s_if.tdata[31:0]);
        run_until(2, 20, "byp_done");

        // Sum mode without saturation: 3 + 4 = 7.
        setup(2'd3, 1'b0, 32'd3);
        gen_pkt(2, 32'd4);
        gen_pkt(2, 32'd4);
        run_until(2, 100, "sum_done");
        if (hdr_q.size() > 1) chk("sum_spacing", 32'(hdr_q[1] - hdr_q[0]), 32'd7);

        // Sum saturates at all-ones: the next header stays withheld.
        setup(2'd3, 1'b0, 32'h20);
        gen_pkt(2, 32'hFFFF_FFF0);
        gen_pkt(2, 32'hFFFF_FFF0);
        run_until(1, 50, "sat_first");
        repeat (1000) tick();
        chk("sat_hdr_count", 32'(hdr_q.size()), 32'd1);
        chk("sat_pkt_count", pkt_count, 32'd1);
        chk("sat_m_tvalid", 32'(m_if.tvalid), 32'd0);

        // Soft reset mid-packet.
        setup(2'd1, 1'b0, 32'd0);
        gen_pkt(1, 32'd0);
        gen_pkt(4, 32'd0);
        b = 0;
        while (mbeats < 3 && b < 50) begin tick(); b++; end
        chk("swr_pre_count", pkt_count, 32'd1);
        sw_rst = 1'b1;
        src_en = 1'b0;
        tick();
        sw_rst = 1'b0;
        #1;
        chk("swr_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("swr_pkt_count", pkt_count, 32'd0);
        clr_tb();
        repeat (2) tick();
        chk("swr_flushed", 32'(m_if.tvalid), 32'd0);
        gen_pkt(1, 32'd0);
        src_en = 1'b1;
        run_until(1, 20, "swr_next");
        if (hdr_q.size() > 0) chk("swr_latency", 32'(hdr_q[0] - wr_t), 32'd1);

        // Asynchronous reset while a header is waiting.
        gen_pkt(2, 32'd0);
        rdy_val = 1'b0;
        repeat (4) tick();
        chk("arst_pre_valid", 32'(m_if.tvalid), 32'd1);
        chk("arst_pre_count", pkt_count, 32'd1);
        #2;
        axi_aresetn = 1'b0;
        #1;
        chk("arst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("arst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("arst_s_tready", 32'(s_if.tready), 32'd0);
        chk("arst_pkt_count", pkt_count, 32'd0);
        @(posedge clk);
        #1;
        axi_aresetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
